// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execution unit.
// Operands are signed 32-bit; results are signed 64-bit.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef logic signed [63:0] result_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        DONE  = 2'd3
    } exec_state_t;

endpackage

// File: rtl/instr_alu.sv
// Purpose: combinational opcode arithmetic on sign-extended 64-bit operands.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
module instr_alu
    import instr_register_pkg::*;
(
    input  instruction_t instr,
    output result_t      res,
    output logic         div_zero
);

    result_t a;
    result_t b;
    result_t b_safe;

    always_comb begin
        a        = {{32{instr.op_a[31]}}, instr.op_a};
        b        = {{32{instr.op_b[31]}}, instr.op_b};
        div_zero = ((instr.opc == DIV) || (instr.opc == MOD)) && (instr.op_b == '0);
        // Divisor forced non-zero so the dividers never produce X; the caller
        // replaces the result with 0 using div_zero.
        b_safe   = (b == '0) ? 64'sd1 : b;
        res      = '0;
        case (instr.opc)
            ZERO:    res = '0;
            PASSA:   res = a;
            PASSB:   res = b;
            ADD:     res = a + b;
            SUB:     res = a - b;
            MULT:    res = a * b;
            DIV:     res = a / b_safe;
            MOD:     res = a % b_safe;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/instr_exec.sv
// Purpose: walks a run of instruction register entries and executes each one (optional div_err port: DIV_ZERO_ERR_EN).
// Latency: 2 cycles from start to out_valid; one result every 2 cycles at best.
// Backpressure: out_valid/out_ready; results and read_pointer hold while out_ready is low.
module instr_exec
    import instr_register_pkg::*;
#(
    parameter int REG_DEPTH = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  address_t     start_addr,
    input  logic [5:0]   count,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output result_t      result,
    output opcode_t      result_opc,
    output address_t     result_addr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         done
`ifdef DIV_ZERO_ERR_EN
    ,
    output logic         div_err
`endif
);

    exec_state_t state;
    exec_state_t state_d;
    address_t    ptr;
    address_t    ptr_inc;
    logic [5:0]  remaining;
    result_t     alu_res;
    result_t     result_d;
    logic        alu_div_zero;

    instr_alu u_alu (
        .instr    (instruction_word),
        .res      (alu_res),
        .div_zero (alu_div_zero)
    );

    assign result_d     = alu_div_zero ? '0 : alu_res;
    assign ptr_inc      = (ptr == address_t'(REG_DEPTH - 1)) ? '0 : ptr + address_t'(1);
    assign read_pointer = ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = (count == '0) ? DONE : FETCH;
            FETCH:   state_d = VALID;
            VALID:   if (out_ready) state_d = (remaining == '0) ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        out_valid = (state == VALID);
        done      = (state == DONE);
    end

`ifdef DIV_ZERO_ERR_EN
    logic dz_q;
    assign div_err = out_valid & dz_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr         <= '0;
            remaining   <= '0;
            result      <= '0;
            result_opc  <= ZERO;
            result_addr <= '0;
`ifdef DIV_ZERO_ERR_EN
            dz_q        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start && (count != '0)) begin
                        ptr       <= start_addr;
                        remaining <= count - 6'd1;
                    end
                end
                FETCH: begin
                    result      <= result_d;
                    result_opc  <= instruction_word.opc;
                    result_addr <= ptr;
`ifdef DIV_ZERO_ERR_EN
                    dz_q        <= alu_div_zero;
`endif
                end
                VALID: begin
                    if (out_ready && (remaining != '0)) begin
                        ptr       <= ptr_inc;
                        remaining <= remaining - 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_exec.sv
// Directed bench for instr_exec with a scoreboard of expected results per run.
module tb_instr_exec;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    address_t     start_addr;
    logic [5:0]   count;
    address_t     read_pointer;
    instruction_t instruction_word;
    result_t      result;
    opcode_t      result_opc;
    address_t     result_addr;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;
`ifdef DIV_ZERO_ERR_EN
    logic         div_err;
`endif

    always #5 clk = ~clk;

    instr_exec #(.REG_DEPTH(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .start_addr       (start_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .result           (result),
        .result_opc       (result_opc),
        .result_addr      (result_addr),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .busy             (busy),
        .done             (done)
`ifdef DIV_ZERO_ERR_EN
        ,
        .div_err          (div_err)
`endif
    );

    instruction_t mem [32];
    result_t      exp_res [32];
    logic         exp_dz [32];

    assign instruction_word = mem[read_pointer];

    int checks = 0;
    int errors = 0;

    result_t  q_res  [$];
    address_t q_addr [$];
    opcode_t  q_opc  [$];
    logic     q_dz   [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic load(input int idx, input logic [3:0] o, input int a, input int b,
                        input longint e, input logic dz);
        mem[idx].opc  = opcode_t'(o);
        mem[idx].op_a = a;
        mem[idx].op_b = b;
        exp_res[idx]  = e;
        exp_dz[idx]   = dz;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rp"},    64'(read_pointer), 64'd0);
        check({tag, "_res"},   result,            64'd0);
        check({tag, "_opc"},   64'(result_opc),   64'd0);
        check({tag, "_addr"},  64'(result_addr),  64'd0);
        check({tag, "_valid"}, 64'(out_valid),    64'd0);
        check({tag, "_busy"},  64'(busy),         64'd0);
        check({tag, "_done"},  64'(done),         64'd0);
`ifdef DIV_ZERO_ERR_EN
        check({tag, "_derr"},  64'(div_err),      64'd0);
`endif
    endtask

    // Called at a negedge; returns at a negedge with the DUT back in IDLE.
    task automatic run(input address_t sa, input logic [5:0] cnt, input int stall, input bit poke);
        int       n;
        int       w;
        bit       first;
        address_t a;
        result_t  h_res;
        opcode_t  h_opc;
        address_t h_addr;
        address_t h_rp;
        n = int'(cnt);
        for (int k = 0; k < n; k++) begin
            a = address_t'((int'(sa) + k) % 32);
            q_res.push_back(exp_res[a]);
            q_addr.push_back(a);
            q_opc.push_back(mem[a].opc);
            q_dz.push_back(exp_dz[a]);
        end
        out_ready  = (stall == 0);
        start      = 1'b1;
        start_addr = sa;
        count      = cnt;
        @(negedge clk);
        start = 1'b0;
        first = 1'b1;
        if (poke) begin
            start      = 1'b1;
            start_addr = 5'd20;
            count      = 6'd7;
            @(negedge clk);
            start = 1'b0;
        end
        while (q_res.size() > 0) begin
            w = (first && poke) ? 1 : 0;
            while (!out_valid && w < 10) begin
                @(negedge clk);
                w++;
            end
            check("latency", 64'(w), 64'd1);
            if (!out_valid) begin
                q_res.delete(); q_addr.delete(); q_opc.delete(); q_dz.delete();
                break;
            end
            if (stall > 0) begin
                h_res  = result;
                h_opc  = result_opc;
                h_addr = result_addr;
                h_rp   = read_pointer;
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    check("hold_valid", 64'(out_valid),    64'd1);
                    check("hold_res",   result,            h_res);
                    check("hold_opc",   64'(result_opc),   64'(h_opc));
                    check("hold_addr",  64'(result_addr),  64'(h_addr));
                    check("hold_rp",    64'(read_pointer), 64'(h_rp));
                end
                out_ready = 1'b1;
            end
            check("result", result, q_res.pop_front());
            check("opc", 64'(result_opc), 64'(q_opc[0]));
            check("addr", 64'(result_addr), 64'(q_addr[0]));
            check("rp", 64'(read_pointer), 64'(q_addr.pop_front()));
            void'(q_opc.pop_front());
`ifdef DIV_ZERO_ERR_EN
            check("div_err", 64'(div_err), 64'(q_dz[0]));
`endif
            void'(q_dz.pop_front());
            first = 1'b0;
            @(negedge clk);
            if (stall > 0) out_ready = 1'b0;
        end
        check("done_pulse", 64'(done), 64'd1);
        check("done_novalid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("done_end", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i]     = '0;
            exp_res[i] = '0;
            exp_dz[i]  = 1'b0;
        end
        load(3,  4'd3, 5, -7, -64'sd2, 1'b0);
        load(30, 4'd4, 10, 3, 64'sd7, 1'b0);
        load(31, 4'd1, -9, 4, -64'sd9, 1'b0);
        load(0,  4'd2, 1, -123, -64'sd123, 1'b0);
        load(1,  4'd0, 55, 66, 64'sd0, 1'b0);
        load(2,  4'd3, 100, 200, 64'sd300, 1'b0);
        load(5,  4'd5, -65536, 65536, -64'sd4294967296, 1'b0);
        load(6,  4'd6, -7, 2, -64'sd3, 1'b0);
        load(7,  4'd7, -7, 2, -64'sd1, 1'b0);
        load(8,  4'd6, 9, 0, 64'sd0, 1'b1);
        load(9,  4'd7, 5, 0, 64'sd0, 1'b1);
        load(10, 4'd12, 3, 4, 64'sd0, 1'b0);
        load(11, 4'd5, 32'h7fffffff, 32'h7fffffff, 64'sd4611686014132420609, 1'b0);
        load(12, 4'd6, 32'h80000000, -1, 64'sd2147483648, 1'b0);

        reset_n    = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        count      = '0;
        out_ready  = 1'b1;
        #1;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run(5'd3, 6'd1, 0, 1'b0);     // single ADD
        run(5'd30, 6'd4, 0, 1'b0);    // pointer wrap 30,31,0,1
        run(5'd30, 6'd2, 5, 1'b0);    // backpressure
        run(5'd5, 6'd8, 0, 1'b0);     // MULT/DIV/MOD, divide by zero, bad opcode
        run(5'd5, 6'd2, 0, 1'b1);     // start while busy is ignored

        // count = 0: done next cycle, no result
        start = 1'b1;
        count = 6'd0;
        start_addr = 5'd3;
        @(negedge clk);
        start = 1'b0;
        check("cnt0_done", 64'(done), 64'd1);
        check("cnt0_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("cnt0_done_end", 64'(done), 64'd0);
        check("cnt0_valid_end", 64'(out_valid), 64'd0);

        // reset in the middle of a count=8 run
        out_ready  = 1'b0;
        start      = 1'b1;
        start_addr = 5'd10;
        count      = 6'd8;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_valid", 64'(out_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_done", 64'(done), 64'd0);
            check("post_rst_busy", 64'(busy), 64'd0);
        end
        run(5'd0, 6'd3, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
